pc_sequencer: RTL and testbench

- Controller that sequences the program counter register and the instruction-memory fetch for the single-issue LEGv8 core.
- Each instruction it issues the fetch handshake, hands the instruction to decode, then picks and writes the next PC: PC+4, taken-branch target, or fault vector.
- Sits between the PC register (it drives PC_NEXT/PC_WRITE, reads PC_CURRENT), instruction memory, and the decode/control unit.

---
 rtl/pc_seq_pkg.sv | 26 ++
 rtl/pc_sequencer_if.sv | 49 ++++
 rtl/fetch_timer.sv | 39 +++
 rtl/pc_sequencer.sv | 158 +++++++++++++++
 tb/tb_pc_sequencer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and constants for the PC sequencer
//
// Purpose: FSM state encoding, datapath widths and the sequential-PC helper
// used by the sequencer, its interface and the bench.
package pc_seq_pkg;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

  // PC_LOAD is the cycle in which the registered PC_WRITE pulse is visible.
  // The PC register captures at the end of it, so FETCH never sees a stale PC.
  typedef enum logic [2:0] {
    BOOT    = 3'd0,
    FETCH   = 3'd1,
    ISSUE   = 3'd2,
    TRAP    = 3'd3,
    PC_LOAD = 3'd4
  } state_t;

  // Sequential successor of a PC; wraps modulo 2^64.
  function automatic logic [ADDR_W-1:0] seq_pc(input logic [ADDR_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - PC register, instruction memory and decode bundle
//
// Purpose: groups every non-clock signal of the sequencer.
// Ports (master = sequencer view):
//   PC_CURRENT    in   present PC register value
//   PC_NEXT       out  value to load into the PC register
//   PC_WRITE      out  one-cycle PC load enable
//   IMEM_REQ      out  fetch request, held until accepted
//   IMEM_ADDR     out  fetch address
//   IMEM_READY    in   fetch complete, IMEM_RDATA valid
//   IMEM_RDATA    in   fetched instruction word
//   INSTR_OUT     out  registered instruction to decode
//   INSTR_VALID   out  INSTR_OUT valid
//   STALL         in   decode/execute not ready
//   BRANCH_TAKEN  in   resolved branch taken
//   BRANCH_TARGET in   resolved branch target
//   FAULT         out  sticky fault flag
//   FETCH_COUNT   out  accepted fetch count
interface pc_sequencer_if;
  import pc_seq_pkg::*;

  logic [ADDR_W-1:0]  PC_CURRENT;
  logic [ADDR_W-1:0]  PC_NEXT;
  logic               PC_WRITE;
  logic               IMEM_REQ;
  logic [ADDR_W-1:0]  IMEM_ADDR;
  logic               IMEM_READY;
  logic [INSTR_W-1:0] IMEM_RDATA;
  logic [INSTR_W-1:0] INSTR_OUT;
  logic               INSTR_VALID;
  logic               STALL;
  logic               BRANCH_TAKEN;
  logic [ADDR_W-1:0]  BRANCH_TARGET;
  logic               FAULT;
  logic [31:0]        FETCH_COUNT;

  modport master (
    input  PC_CURRENT, IMEM_READY, IMEM_RDATA, STALL, BRANCH_TAKEN, BRANCH_TARGET,
    output PC_NEXT, PC_WRITE, IMEM_REQ, IMEM_ADDR, INSTR_OUT, INSTR_VALID,
           FAULT, FETCH_COUNT
  );

  modport slave (
    output PC_CURRENT, IMEM_READY, IMEM_RDATA, STALL, BRANCH_TAKEN, BRANCH_TARGET,
    input  PC_NEXT, PC_WRITE, IMEM_REQ, IMEM_ADDR, INSTR_OUT, INSTR_VALID,
           FAULT, FETCH_COUNT
  );

endinterface

// File: rtl/fetch_timer.sv
// rtl/fetch_timer.sv - loadable down-counter bounding the instruction fetch wait
//
// Purpose: reloads to FETCH_TIMEOUT-1 while i_clear is high, counts down on
// i_tick and flags o_expire on the last permitted fetch cycle.
// Ports:
//   CLOCK     in   rising-edge clock
//   RESET_N   in   synchronous active-low reset
//   i_clear   in   reload the counter
//   i_tick    in   count one fetch cycle
//   o_expire  out  current cycle is the final counted fetch cycle
module fetch_timer #(
  parameter int FETCH_TIMEOUT = 16
) (
  input  logic CLOCK,
  input  logic RESET_N,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_expire
);

  localparam int CNT_W = $clog2(FETCH_TIMEOUT);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(FETCH_TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      r_count <= LOAD_VAL;
    end else if (i_clear) begin
      r_count <= LOAD_VAL;
    end else if (i_tick && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  // First fetch cycle sees LOAD_VAL, so zero is reached on cycle FETCH_TIMEOUT.
  assign o_expire = (r_count == '0);

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter and instruction fetch sequencer
//
// Purpose: fetches the instruction at PC_CURRENT, hands it to decode, then
// loads PC+4, the taken-branch target or the fault vector into the PC register.
// Ports:
//   CLOCK    in      rising-edge clock
//   RESET_N  in      synchronous active-low reset
//   bus      master  PC register / instruction memory / decode bundle
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                FETCH_TIMEOUT = 16,
  parameter logic [ADDR_W-1:0] FAULT_VECTOR  = 64'h0000_0000_0000_0080
) (
  input  logic           CLOCK,
  input  logic           RESET_N,
  pc_sequencer_if.master bus
);

  state_t             r_state;
  state_t             w_state_next;

  logic               r_pc_write;
  logic [ADDR_W-1:0]  r_pc_next;
  logic [INSTR_W-1:0] r_instr;
  logic [31:0]        r_fetch_count;
  logic               r_fault;

  logic               w_imem_req;
  logic [ADDR_W-1:0]  w_imem_addr;
  logic               w_instr_valid;
  logic               w_pc_write_d;
  logic [ADDR_W-1:0]  w_pc_next_d;
  logic               w_fetch_accept;
  logic               w_set_fault;
  logic               w_expire;
  logic               w_target_aligned;

  assign w_target_aligned = (bus.BRANCH_TARGET[1:0] == 2'b00);

  fetch_timer #(
    .FETCH_TIMEOUT(FETCH_TIMEOUT)
  ) u_fetch_timer (
    .CLOCK    (CLOCK),
    .RESET_N  (RESET_N),
    .i_clear  (r_state != FETCH),
    .i_tick   (r_state == FETCH),
    .o_expire (w_expire)
  );

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BOOT:    w_state_next = PC_LOAD;
      PC_LOAD: w_state_next = FETCH;
      FETCH: begin
        // READY on the final counted cycle takes priority over the timeout.
        if (bus.IMEM_READY) begin
          w_state_next = ISSUE;
        end else if (w_expire) begin
          w_state_next = TRAP;
        end
      end
      ISSUE: begin
        if (!bus.STALL) begin
          if (bus.BRANCH_TAKEN && !w_target_aligned) begin
            w_state_next = TRAP;
          end else begin
            w_state_next = PC_LOAD;
          end
        end
      end
      TRAP:    w_state_next = PC_LOAD;
      default: w_state_next = BOOT;
    endcase
  end

  always_comb begin
    w_imem_req     = 1'b0;
    w_imem_addr    = '0;
    w_instr_valid  = 1'b0;
    w_pc_write_d   = 1'b0;
    w_pc_next_d    = '0;
    w_fetch_accept = 1'b0;
    w_set_fault    = 1'b0;
    case (r_state)
      BOOT: begin
        w_pc_write_d = 1'b1;
      end
      FETCH: begin
        w_imem_req     = 1'b1;
        w_imem_addr    = bus.PC_CURRENT;
        w_fetch_accept = bus.IMEM_READY;
      end
      ISSUE: begin
        w_instr_valid = 1'b1;
        if (!bus.STALL) begin
          if (!bus.BRANCH_TAKEN) begin
            w_pc_write_d = 1'b1;
            w_pc_next_d  = seq_pc(bus.PC_CURRENT);
          end else if (w_target_aligned) begin
            w_pc_write_d = 1'b1;
            w_pc_next_d  = bus.BRANCH_TARGET;
          end
        end
      end
      TRAP: begin
        w_pc_write_d = 1'b1;
        w_pc_next_d  = FAULT_VECTOR;
        w_set_fault  = 1'b1;
      end
      default: begin
        w_imem_req = 1'b0;
      end
    endcase
  end

  // PC_NEXT holds its last loaded value; INSTR_OUT only changes on an accepted fetch.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      r_pc_write    <= 1'b0;
      r_pc_next     <= '0;
      r_instr       <= '0;
      r_fetch_count <= '0;
      r_fault       <= 1'b0;
    end else begin
      r_pc_write <= w_pc_write_d;
      if (w_pc_write_d) begin
        r_pc_next <= w_pc_next_d;
      end
      if (w_fetch_accept) begin
        r_instr       <= bus.IMEM_RDATA;
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (w_set_fault) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign bus.PC_NEXT     = r_pc_next;
  assign bus.PC_WRITE    = r_pc_write;
  assign bus.IMEM_REQ    = w_imem_req;
  assign bus.IMEM_ADDR   = w_imem_addr;
  assign bus.INSTR_OUT   = r_instr;
  assign bus.INSTR_VALID = w_instr_valid;
  assign bus.FAULT       = r_fault;
  assign bus.FETCH_COUNT = r_fetch_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int          T  = 16;
  localparam logic [63:0] FV = 64'h0000_0000_0000_0080;

  logic CLOCK   = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLOCK = ~CLOCK;

  pc_sequencer_if bus();

  pc_sequencer #(
    .FETCH_TIMEOUT(T),
    .FAULT_VECTOR (FV)
  ) dut (
    .CLOCK  (CLOCK),
    .RESET_N(RESET_N),
    .bus    (bus)
  );

  // PC register modelled by the bench.
  logic [63:0] pc_reg = 64'h0BAD_0BAD_0BAD_0BAD;
  always @(posedge CLOCK) if (bus.PC_WRITE) pc_reg <= bus.PC_NEXT;
  assign bus.PC_CURRENT = pc_reg;

  int cyc = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  typedef struct packed { logic [63:0] pc; logic fault; } pcw_t;
  typedef struct packed { logic [31:0] instr; logic [31:0] cnt; } iss_t;

  pcw_t        q_pc[$];
  logic [63:0] q_fetch[$];
  iss_t        q_iss[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural reference state.
  logic [63:0] model_pc;
  logic [31:0] model_count;
  logic        model_fault;
  int          prev_acc;
  bit          prev_acc_valid;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic record_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event not expected by the reference (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT presents a result.
  pcw_t m_pcw;
  logic [63:0] m_addr;
  always @(negedge CLOCK) begin
    if (RESET_N) begin
      check64("req_valid_exclusive", 64'(bus.IMEM_REQ & bus.INSTR_VALID), 64'd0);
      if (bus.PC_WRITE) begin
        if (q_pc.size() == 0) record_fail("unexpected_pc_write");
        else begin
          m_pcw = q_pc.pop_front();
          check64("pc_next", bus.PC_NEXT, m_pcw.pc);
          check64("fault_at_write", 64'(bus.FAULT), 64'(m_pcw.fault));
        end
      end
      if (bus.IMEM_REQ && bus.IMEM_READY) begin
        if (q_fetch.size() == 0) record_fail("unexpected_fetch_accept");
        else begin
          m_addr = q_fetch.pop_front();
          check64("imem_addr", bus.IMEM_ADDR, m_addr);
        end
      end
      if (bus.INSTR_VALID) begin
        if (q_iss.size() == 0) record_fail("unexpected_instr_valid");
        else begin
          check64("instr_out", 64'(bus.INSTR_OUT), 64'(q_iss[0].instr));
          check64("fetch_count", 64'(bus.FETCH_COUNT), 64'(q_iss[0].cnt));
          if (!bus.STALL) void'(q_iss.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!bus.IMEM_REQ && n < 40) begin
      step();
      n++;
    end
    if (!bus.IMEM_REQ) record_fail("wait_imem_req_timeout");
  endtask

  task automatic check_reset_outputs(input string tag);
    check64({tag, "_pc_write"}, 64'(bus.PC_WRITE), 64'd0);
    check64({tag, "_pc_next"}, bus.PC_NEXT, 64'd0);
    check64({tag, "_imem_req"}, 64'(bus.IMEM_REQ), 64'd0);
    check64({tag, "_imem_addr"}, bus.IMEM_ADDR, 64'd0);
    check64({tag, "_instr_valid"}, 64'(bus.INSTR_VALID), 64'd0);
    check64({tag, "_instr_out"}, 64'(bus.INSTR_OUT), 64'd0);
    check64({tag, "_fetch_count"}, 64'(bus.FETCH_COUNT), 64'd0);
    check64({tag, "_fault"}, 64'(bus.FAULT), 64'd0);
  endtask

  task automatic do_release();
    q_pc.delete();
    q_fetch.delete();
    q_iss.delete();
    model_pc       = 64'd0;
    model_count    = 32'd0;
    model_fault    = 1'b0;
    prev_acc_valid = 1'b0;
    q_pc.push_back('{64'd0, 1'b0});
    RESET_N = 1'b1;
    step();
    check64("boot_pc_write", 64'(bus.PC_WRITE), 64'd1);
    check64("boot_pc_next", bus.PC_NEXT, 64'd0);
  endtask

  // One instruction: READY after d wait cycles (timeout if d+1 > T), s stall
  // cycles with random branch noise, then the given branch outcome.
  task automatic run_instr(input int d, input int s, input bit taken, input logic [63:0] tgt);
    int reqs;
    logic [31:0] rd;
    bus.IMEM_READY = 1'b0;
    wait_req();
    if (d + 1 > T) begin
      reqs = 0;
      while (bus.IMEM_REQ && reqs < T + 4) begin
        reqs++;
        step();
      end
      check64("timeout_req_cycles", 64'(reqs), 64'(T));
      model_fault = 1'b1;
      model_pc    = FV;
      q_pc.push_back('{FV, 1'b1});
      prev_acc_valid = 1'b0;
      return;
    end
    for (int k = 0; k < d; k++) begin
      check64("req_held", 64'(bus.IMEM_REQ), 64'd1);
      step();
    end
    rd = $urandom;
    q_fetch.push_back(model_pc);
    bus.IMEM_READY = 1'b1;
    bus.IMEM_RDATA = rd;
    if (prev_acc_valid && d == 0) check64("fetch_period", 64'(cyc - prev_acc), 64'd3);
    prev_acc = cyc;
    step();
    bus.IMEM_READY = 1'b0;
    bus.IMEM_RDATA = $urandom;
    model_count = model_count + 32'd1;
    q_iss.push_back('{rd, model_count});
    for (int k = 0; k < s; k++) begin
      bus.STALL         = 1'b1;
      bus.BRANCH_TAKEN  = 1'($urandom_range(0, 1));
      bus.BRANCH_TARGET = {$urandom, $urandom};
      step();
    end
    bus.STALL         = 1'b0;
    bus.BRANCH_TAKEN  = taken;
    bus.BRANCH_TARGET = tgt;
    if (taken && tgt[1:0] != 2'b00) begin
      model_fault = 1'b1;
      model_pc    = FV;
    end else if (taken) begin
      model_pc = tgt;
    end else begin
      model_pc = model_pc + 64'd4;
    end
    q_pc.push_back('{model_pc, model_fault});
    prev_acc_valid = (s == 0) && !(taken && tgt[1:0] != 2'b00);
    step();
    bus.BRANCH_TAKEN  = 1'b0;
    bus.BRANCH_TARGET = 64'd0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    int s;
    int r;
    logic [63:0] tgt;
    bit taken;

    bus.IMEM_READY    = 1'b1;
    bus.IMEM_RDATA    = 32'hA5A5_0001;
    bus.STALL         = 1'b0;
    bus.BRANCH_TAKEN  = 1'b0;
    bus.BRANCH_TARGET = 64'd0;
    RESET_N           = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");

    do_release();

    // Sequential fetches with immediate READY: 0, 4, 8, ... every 3 cycles.
    for (int i = 0; i < 6; i++) run_instr(0, 0, 1'b0, 64'd0);

    // Branch from 0x100 to 0x2000, then on to 0x40.
    run_instr(0, 0, 1'b1, 64'h100);
    run_instr(0, 0, 1'b1, 64'h2000);
    run_instr(0, 0, 1'b1, 64'h40);

    // Stall at 0x40 for 5 cycles with branch noise, then fall through to 0x44.
    run_instr(0, 5, 1'b0, 64'd0);

    // READY on the last counted fetch cycle is accepted without a fault.
    run_instr(T - 1, 0, 1'b0, 64'd0);
    run_instr(0, 0, 1'b0, 64'd0);

    // Misaligned target traps; the fault stays set across later instructions.
    run_instr(0, 0, 1'b1, 64'h2002);
    run_instr(1, 0, 1'b0, 64'd0);

    // Fetch timeout.
    run_instr(T + 3, 0, 1'b0, 64'd0);
    run_instr(0, 0, 1'b0, 64'd0);

    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 15);
      if (r < 10)       d = $urandom_range(0, 2);
      else if (r < 12)  d = T - 1;
      else if (r == 12) d = T + 2;
      else              d = $urandom_range(3, 8);
      s = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      taken = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 15);
      tgt = {$urandom, $urandom};
      if (r == 0) begin
        tgt[1:0] = 2'($urandom_range(1, 3));
      end else if (r == 1) begin
        tgt = 64'hFFFF_FFFF_FFFF_FFFC;
      end else begin
        tgt[1:0] = 2'b00;
      end
      run_instr(d, s, taken, tgt);
    end

    // PC+4 wraps from the top of the address space to 0.
    run_instr(0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    run_instr(0, 0, 1'b0, 64'd0);

    // Reset in the middle of a fetch with READY presented during reset.
    bus.IMEM_READY = 1'b0;
    wait_req();
    check64("pre_reset_addr", bus.IMEM_ADDR, 64'd0);
    RESET_N        = 1'b0;
    bus.IMEM_READY = 1'b1;
    bus.IMEM_RDATA = 32'hDEAD_BEEF;
    step();
    check_reset_outputs("mid_fetch_reset");
    step();
    check_reset_outputs("reset_ready_ignored");

    do_release();
    for (int i = 0; i < 4; i++) run_instr($urandom_range(0, 2), 0, 1'b0, 64'd0);

    repeat (4) step();
    check64("q_pc_drained", 64'(q_pc.size()), 64'd0);
    check64("q_fetch_drained", 64'(q_fetch.size()), 64'd0);
    check64("q_iss_drained", 64'(q_iss.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
